aes_key_expansion: RTL and testbench



---
 rtl/aes_pkg.sv | 47 ++++
 rtl/aes_sbox.sv | 14 +
 rtl/aes_key_expansion.sv | 158 +++++++++++++++
 tb/tb_aes_key_expansion.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// AES shared definitions.
// Holds the key-expansion FSM state type, the round-constant table, the
// AES-128 size constants and the forward S-box. The S-box lives here so the
// future sub_bytes datapath can use the same table as the key schedule.
package aes_pkg;

  localparam int AES_ROUNDS = 10;
  localparam int KEY_W      = 128;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Round constants for rounds 0..9, applied to the top byte of the temp word.
  localparam logic [7:0] RCON [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Forward S-box, entry 0x00 in the most significant byte so the literal
  // reads row by row in the usual 16x16 layout.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x sits at bit offset (255 - x) * 8, and 255 - x is simply ~x.
  function automatic logic [7:0] sbox_lookup(input logic [7:0] x);
    return SBOX_TABLE[{~x, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Single-byte AES forward S-box, purely combinational.
// Ports:
//   in_byte  - byte to substitute
//   out_byte - substituted byte
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_byte,
  output logic [7:0] out_byte
);

  assign out_byte = sbox_lookup(in_byte);

endmodule

// File: rtl/aes_key_expansion.sv
// AES-128 key schedule generator.
// On an accepted start the cipher key is written as round key 0, then one
// expanded round key per clock until round key 10, driving the key register
// write port directly. A single-cycle done pulse follows the last write.
// Ports:
//   clk          - system clock, rising edge
//   rst          - asynchronous active-high reset
//   start        - expansion request, only honoured while idle
//   cipher_key   - initial key, w0 in [127:96], captured on accepted start
//   key_out      - round key being written (registered)
//   iter_in      - round index of key_out, 0..10 (registered)
//   key_reg_load - key register write strobe (registered)
//   busy         - expansion in progress
//   done         - one-cycle pulse after round key 10 is written
module aes_key_expansion
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] cipher_key,
  output logic [KEY_W-1:0] key_out,
  output logic [3:0]       iter_in,
  output logic             key_reg_load,
  output logic             busy,
  output logic             done
);

  if (NUM_ROUNDS != AES_ROUNDS) begin : g_bad_rounds
    $error("aes_key_expansion: only NUM_ROUNDS=10 (AES-128) is supported");
  end

  // Round index of the final expansion step (the one producing key 10).
  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  state_e           state_q, state_d;
  logic [3:0]       round_q, round_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [KEY_W-1:0] key_out_q, key_out_d;
  logic [3:0]       iter_in_q, iter_in_d;
  logic             key_reg_load_q, key_reg_load_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [31:0]      w0, w1, w2, w3;
  logic [31:0]      rot_word, sub_word, temp_word;
  logic [31:0]      n0, n1, n2, n3;
  logic [7:0]       rcon_sel;
  logic [KEY_W-1:0] next_key;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  // RotWord: left byte rotate of the last word.
  assign rot_word = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_sub_word
    aes_sbox u_sbox (
      .in_byte  (rot_word[8*i +: 8]),
      .out_byte (sub_word[8*i +: 8])
    );
  end

  // round_q reaches 10 only in the DONE cycle, where next_key is unused.
  always_comb begin
    rcon_sel = 8'h00;
    if (round_q < 4'd10) begin
      rcon_sel = RCON[round_q];
    end
  end

  assign temp_word = sub_word ^ {rcon_sel, 24'h000000};
  assign n0        = w0 ^ temp_word;
  assign n1        = w1 ^ n0;
  assign n2        = w2 ^ n1;
  assign n3        = w3 ^ n2;
  assign next_key  = {n0, n1, n2, n3};

  always_comb begin
    state_d        = state_q;
    round_d        = round_q;
    key_d          = key_q;
    key_out_d      = key_out_q;
    iter_in_d      = iter_in_q;
    key_reg_load_d = key_reg_load_q;
    busy_d         = busy_q;
    done_d         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        key_reg_load_d = 1'b0;
        if (start) begin
          key_d          = cipher_key;
          key_out_d      = cipher_key;
          iter_in_d      = 4'd0;
          key_reg_load_d = 1'b1;
          busy_d         = 1'b1;
          round_d        = 4'd0;
          state_d        = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        key_d          = next_key;
        key_out_d      = next_key;
        iter_in_d      = round_q + 4'd1;
        round_d        = round_q + 4'd1;
        key_reg_load_d = 1'b1;
        if (round_q == LAST_ROUND) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        key_reg_load_d = 1'b0;
        busy_d         = 1'b0;
        done_d         = 1'b1;
        state_d        = ST_IDLE;
      end
      default: begin
        key_reg_load_d = 1'b0;
        busy_d         = 1'b0;
        state_d        = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      round_q        <= 4'd0;
      key_q          <= '0;
      key_out_q      <= '0;
      iter_in_q      <= 4'd0;
      key_reg_load_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      round_q        <= round_d;
      key_q          <= key_d;
      key_out_q      <= key_out_d;
      iter_in_q      <= iter_in_d;
      key_reg_load_q <= key_reg_load_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

  assign key_out      = key_out_q;
  assign iter_in      = iter_in_q;
  assign key_reg_load = key_reg_load_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Testbench for aes_key_expansion.
// A word-level FIPS-197 key schedule (S-box derived from GF(2^8) inversion and
// the affine map, round constants by repeated doubling) predicts every output
// on every cycle; literal vectors pin that model.
module tb_aes_key_expansion;

  localparam logic [127:0] KEY_A1   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] A1_R1    = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] A1_R10   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk;
  logic         rst;
  logic         start;
  logic [127:0] cipher_key;
  logic [127:0] key_out;
  logic [3:0]   iter_in;
  logic         key_reg_load;
  logic         busy;
  logic         done;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Per-run capture filled by applyStimulus.
  logic [127:0] cap [0:15];
  int           writes;
  int           dones;
  int           first_write;

  aes_key_expansion #(.NUM_ROUNDS(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .cipher_key   (cipher_key),
    .key_out      (key_out),
    .iter_in      (iter_in),
    .key_reg_load (key_reg_load),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] inv = 8'h00;
    if (x != 8'h00) begin
      for (int y = 1; y < 256; y++) begin
        if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
      end
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [0:10][127:0] expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    logic [0:10][127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_model(t[31:24]), sbox_model(t[23:16]), sbox_model(t[15:8]), sbox_model(t[7:0])};
        t = t ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) res[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return res;
  endfunction

  // m_pos: -1 idle, 0..10 index of the key on the bus, 11 the done cycle.
  int                 m_pos = -1;
  logic [0:10][127:0] m_sched;
  logic [127:0]       m_key;
  logic [3:0]         m_iter;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pos  <= -1;
      m_key  <= '0;
      m_iter <= '0;
    end else if (m_pos >= 0 && m_pos < 10) begin
      m_pos  <= m_pos + 1;
      m_key  <= m_sched[m_pos + 1];
      m_iter <= m_iter + 4'd1;
    end else if (m_pos == 10) begin
      m_pos <= 11;
    end else if (start) begin
      m_sched <= expand(cipher_key);
      m_key   <= cipher_key;
      m_iter  <= 4'd0;
      m_pos   <= 0;
    end else begin
      m_pos <= -1;
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("key_out", key_out, m_key);
      checkOutput("iter_in", {124'd0, iter_in}, {124'd0, m_iter});
      checkOutput("key_reg_load", {127'd0, key_reg_load}, {127'd0, (m_pos >= 0 && m_pos <= 10)});
      checkOutput("busy", {127'd0, busy}, {127'd0, (m_pos >= 0 && m_pos <= 10)});
      checkOutput("done", {127'd0, done}, {127'd0, (m_pos == 11)});
    end
  end

  // ---------------- stimulus ----------------
  // Launches one expansion and records every write until done (bounded).
  // chained: caller is already at the negedge of the done cycle.
  task automatic applyStimulus(input logic [127:0] key, input bit hold, input bit scramble, input bit chained);
    if (!chained) @(negedge clk);
    cipher_key  = key;
    start       = 1'b1;
    writes      = 0;
    dones       = 0;
    first_write = -1;
    for (int c = 0; c < 40 && dones == 0; c++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (scramble) cipher_key = {$urandom, $urandom, $urandom, $urandom};
      if (key_reg_load) begin
        if (first_write < 0) first_write = c;
        cap[iter_in] = key_out;
        writes++;
      end
      if (done) dones++;
    end
    start = 1'b0;
    if (dones == 0) begin
      total++;
      bad++;
      $display("[TB] FAIL run timeout: got no done expected done within 40 cycles");
    end
  endtask

  task automatic checkRun(input string tag, input logic [127:0] key);
    logic [0:10][127:0] s;
    s = expand(key);
    checkOutput({tag, " writes"}, 128'(writes), 128'd11);
    checkOutput({tag, " dones"}, 128'(dones), 128'd1);
    checkOutput({tag, " first write"}, 128'(first_write), 128'd0);
    for (int r = 0; r < 11; r++) checkOutput($sformatf("%s key%0d", tag, r), cap[r], s[r]);
  endtask

  initial begin
    logic [0:10][127:0] s;
    logic [127:0]       k;
    int                 n;

    rst        = 1'b0;
    start      = 1'b0;
    cipher_key = '0;

    // Mid-cycle asynchronous reset clears outputs without a clock edge.
    #13 rst = 1'b1;
    #1;
    checkOutput("rst key_out", key_out, 128'd0);
    checkOutput("rst iter_in", {124'd0, iter_in}, 128'd0);
    checkOutput("rst load", {127'd0, key_reg_load}, 128'd0);
    checkOutput("rst busy", {127'd0, busy}, 128'd0);
    checkOutput("rst done", {127'd0, done}, 128'd0);
    chk_en = 1'b1;

    // Pin the model to the published vectors.
    s = expand(KEY_A1);
    checkOutput("model a1 r1", s[1], A1_R1);
    checkOutput("model a1 r10", s[10], A1_R10);
    s = expand(128'd0);
    checkOutput("model zero r1", s[1], ZERO_R1);
    checkOutput("model zero r10", s[10], ZERO_R10);

    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checkOutput("idle load", {127'd0, key_reg_load}, 128'd0);
    end

    $display("[TB] FIPS-197 A.1 key");
    applyStimulus(KEY_A1, 1'b0, 1'b0, 1'b0);
    checkRun("a1", KEY_A1);
    checkOutput("a1 lit r1", cap[1], A1_R1);
    checkOutput("a1 lit r10", cap[10], A1_R10);
    repeat (3) @(negedge clk);

    $display("[TB] zero key, start held, key scrambled mid-run");
    applyStimulus(128'd0, 1'b1, 1'b1, 1'b0);
    checkRun("zero", 128'd0);
    checkOutput("zero lit r1", cap[1], ZERO_R1);
    checkOutput("zero lit r10", cap[10], ZERO_R10);
    repeat (2) @(negedge clk);

    $display("[TB] reset at iter 5");
    @(negedge clk);
    cipher_key = KEY_A1;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(key_reg_load && iter_in == 4'd5) && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reach iter5", {124'd0, iter_in}, 128'd5);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst5 load", {127'd0, key_reg_load}, 128'd0);
    checkOutput("rst5 busy", {127'd0, busy}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(KEY_A1, 1'b0, 1'b0, 1'b0);
    checkRun("after rst", KEY_A1);

    $display("[TB] back-to-back");
    repeat (2) @(negedge clk);
    applyStimulus(KEY_A1, 1'b0, 1'b0, 1'b0);
    checkRun("b2b first", KEY_A1);
    applyStimulus(128'd0, 1'b0, 1'b0, 1'b1);
    checkRun("b2b second", 128'd0);
    checkOutput("b2b lit r10", cap[10], ZERO_R10);

    $display("[TB] random keys");
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      k = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(k, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      checkRun("random", k);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
